// File: rtl/uart_pkg.sv
// Shared definitions for the UART response framer: FSM state encoding,
// default frame start byte and the additive checksum helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_HEADER  = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4
    } state_e;

    localparam logic [7:0] FRAME_HEADER = 8'hAA;

    // Running 8-bit additive checksum step; wraps modulo 256.
    function automatic logic [7:0] csum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_tx_framer_frame_buf.sv
// Payload buffer for the framer: DEPTH x 8 register file with one
// synchronous write port and one combinational read port.
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_framer.sv
// Collects one response payload, then emits HEADER, length, payload and
// checksum bytes to the UART transmitter over a valid/ready byte interface.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] HEADER  = FRAME_HEADER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       ovf_err,
    output logic [2:0] dbg_state
);

    // Handshake: a byte moves on every clock edge where tx_data_valid is 1.
    // tx_data_valid only rises while the transmitter reports ready, and
    // in_ready is high exactly while payload is being collected.

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    sum_q, sum_d;
    logic          ovf_seen_q, ovf_seen_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          room;
    logic          drop;
    logic          handoff;
    logic [7:0]    rd_data;

    assign accept  = (state_q == S_COLLECT) && in_valid;
    assign room    = (count_q < MAX_CNT);
    assign drop    = accept && !room;
    assign handoff = tx_data_valid;

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i     (clk),
        .wr_en_i   (accept && room),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        sum_d        = sum_q;
        ovf_seen_d   = ovf_seen_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    if (room) begin
                        count_d = count_q + ONE;
                        sum_d   = csum8(sum_q, in_data);
                    end else begin
                        ovf_seen_d = 1'b1;
                    end
                    // A dropped last byte still closes the frame.
                    if (in_last) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: if (handoff) state_d = S_LEN;
            S_LEN:    if (handoff) state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (handoff) begin
                    rd_ptr_d = rd_ptr_q + ONE;
                    if (rd_ptr_q == count_q - ONE) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (handoff) begin
                    state_d      = S_COLLECT;
                    count_d      = '0;
                    rd_ptr_d     = '0;
                    sum_d        = '0;
                    ovf_seen_d   = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            sum_q        <= '0;
            ovf_seen_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            sum_q        <= sum_d;
            ovf_seen_q   <= ovf_seen_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        tx_data = HEADER;
        unique case (state_q)
            S_LEN:     tx_data = 8'(count_q);
            S_PAYLOAD: tx_data = rd_data;
            S_CSUM:    tx_data = csum8(8'(count_q), sum_q);
            default:   tx_data = HEADER;
        endcase
    end

    assign tx_data_valid = (state_q != S_COLLECT) && tx_data_ready && !rst;
    assign in_ready      = (state_q == S_COLLECT);
    assign busy          = (state_q != S_COLLECT);
    assign frame_done    = frame_done_q;
    assign ovf_err       = drop && !ovf_seen_q && !rst;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed and randomized bench for uart_tx_framer with a transmitter
// model and a frame-level reference model.
module tb_uart_tx_framer;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       busy;
    logic       frame_done;
    logic       ovf_err;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl_q[$];

    int         done_cnt = 0;
    int         ovf_cnt  = 0;
    int         viol_cnt = 0;
    logic [7:0] ovf_byte = 8'h00;
    logic       handoff_seen = 1'b0;
    logic       stall_tx;
    int         gap = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .ovf_err       (ovf_err),
        .dbg_state     (dbg_state)
    );

    // Monitor: samples away from the active edge.
    always @(negedge clk) begin
        handoff_seen = tx_data_valid;
        if (tx_data_valid) begin
            got_q.push_back(tx_data);
            if (!tx_data_ready) viol_cnt++;
        end
        if (frame_done) done_cnt++;
        if (ovf_err) begin
            ovf_cnt++;
            ovf_byte = in_data;
        end
    end

    // Transmitter model: registered ready, low after reset and after each
    // accepted byte, plus a random idle gap.
    always @(posedge clk) begin
        if (rst) begin
            tx_data_ready <= 1'b0;
            gap           <= 0;
        end else if (stall_tx || handoff_seen) begin
            tx_data_ready <= 1'b0;
            if (handoff_seen) gap <= $urandom_range(0, 2);
        end else if (gap != 0) begin
            gap <= gap - 1;
        end else begin
            tx_data_ready <= 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: header, kept length, kept bytes, (length + sum) mod 256.
    task automatic model_frame();
        int n;
        int sum;
        n   = (pl_q.size() > MAX_LEN) ? MAX_LEN : pl_q.size();
        sum = n;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl_q[i]);
            sum = sum + int'(pl_q[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic send_payload(input string tag, input int max_idle);
        logic acc;
        logic all_ok;
        int   cyc;
        int   idle;
        all_ok = 1'b1;
        for (int i = 0; i < pl_q.size(); i++) begin
            idle = (max_idle > 0) ? $urandom_range(0, max_idle) : 0;
            repeat (idle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = pl_q[i];
            in_last  = (i == pl_q.size() - 1);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 1000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) all_ok = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_accept"}, all_ok, 1'b1);
    endtask

    task automatic compare_bytes(input string tag, input int base_g);
        logic [31:0] obs;
        check({tag, "_nbytes"}, got_q.size() - base_g, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base_g + i < got_q.size()) ? {24'h0, got_q[base_g + i]} : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
    endtask

    task automatic run_frame(input string tag, input int max_idle, input int stall_cycles);
        int base_g, base_d, base_o, cyc, bad;
        base_g = got_q.size();
        base_d = done_cnt;
        base_o = ovf_cnt;
        exp_q.delete();
        model_frame();
        send_payload(tag, max_idle);
        @(negedge clk);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_first_valid"}, tx_data_valid, tx_data_ready);
        if (stall_cycles > 0) begin
            bad = 0;
            repeat (stall_cycles) begin
                @(negedge clk);
                if (tx_data_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
            end
            check({tag, "_stall"}, bad, 0);
            stall_tx = 1'b0;
        end
        cyc = 0;
        while (done_cnt == base_d && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - base_d, 1);
        compare_bytes(tag, base_g);
        check({tag, "_ovf"}, ovf_cnt - base_o, (pl_q.size() > MAX_LEN) ? 1 : 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   base_g, base_d, cyc;
        logic acc, fd;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        stall_tx = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", tx_data_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_tx_data", tx_data, 8'hAA);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        pl_q = '{8'h01, 8'h02, 8'h03};
        run_frame("t123", 0, 0);

        pl_q = '{8'hFF};
        run_frame("tff", 0, 0);

        pl_q.delete();
        for (int i = 0; i < MAX_LEN + 2; i++) pl_q.push_back(8'(8'h10 + i));
        run_frame("tovf", 0, 0);
        check("tovf_first_drop", ovf_byte, 8'(8'h10 + MAX_LEN));

        stall_tx = 1'b1;
        @(posedge clk); #1;
        pl_q = '{8'h05, 8'h06};
        run_frame("tstall", 0, 100);

        // Reset right after the length byte is handed off.
        stall_tx = 1'b1;
        @(posedge clk); #1;
        base_g = got_q.size();
        base_d = done_cnt;
        pl_q = '{8'h07, 8'h08, 8'h09};
        send_payload("trst", 0);
        stall_tx = 1'b0;
        cyc = 0;
        while (got_q.size() < base_g + 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        stall_tx = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_tx = 1'b0;
        repeat (20) @(negedge clk);
        check("trst_nbytes", got_q.size() - base_g, 2);
        check("trst_busy", busy, 1'b0);
        check("trst_in_ready", in_ready, 1'b1);
        check("trst_done", done_cnt - base_d, 0);
        @(posedge clk); #1;
        pl_q = '{8'hAB};
        run_frame("tpost", 0, 0);

        // in_valid held across frame_done: next byte taken in that cycle.
        base_g = got_q.size();
        base_d = done_cnt;
        exp_q.delete();
        pl_q = '{8'h31};
        model_frame();
        pl_q = '{8'h32};
        model_frame();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'h31;
        @(negedge clk);
        @(posedge clk); #1;
        in_data = 8'h32;
        acc = 1'b0;
        fd  = 1'b0;
        cyc = 0;
        while (!acc && cyc < 500) begin
            @(negedge clk);
            acc = in_ready;
            fd  = frame_done;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("tb2b_accept_in_done_cycle", fd, 1'b1);
        cyc = 0;
        while (done_cnt < base_d + 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check("tb2b_done_pulses", done_cnt - base_d, 2);
        compare_bytes("tb2b", base_g);
        @(posedge clk); #1;

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, MAX_LEN + 4);
            pl_q.delete();
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
            run_frame($sformatf("rnd%0d", f), 2, 0);
        end

        check("valid_without_ready", viol_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Response framer that sits directly upstream of the UART transmitter in the command handler. It collects one variable-length response payload from the command logic into an internal buffer. It then emits a frame of header byte, length byte, payload and 8-bit checksum, one byte at a time, over the transmitter's valid/ready byte interface. Input is back-pressured while a frame is being sent.

## Interface
- `MAX_LEN`, 16: payload buffer depth in bytes, legal range 1..255.
- `HEADER`, 8'hAA: frame start byte.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: payload byte from the command logic.
- `in_valid` input 1: `in_data` is valid.
- `in_last` input 1: qualifies the final payload byte of the response.
- `in_ready` output 1: block accepts a payload byte.
- `tx_data` output 8: byte to the transmitter.
- `tx_data_valid` output 1: `tx_data` is valid.
- `tx_data_ready` input 1: transmitter is idle and accepts a byte. This is a registered signal from the transmitter.
- `busy` output 1: a frame is being emitted (high in every state except S_COLLECT).
- `frame_done` output 1: one-cycle pulse after the checksum byte is handed off.
- `ovf_err` output 1: one-cycle pulse on the first payload byte dropped because the buffer is full.

## Operation
- States: S_COLLECT, S_HEADER, S_LEN, S_PAYLOAD, S_CSUM. Reset state is S_COLLECT.
- **S_COLLECT**
  - `in_ready`=1.
  - On `in_valid`: if count<MAX_LEN, write `in_data` at buffer[count], increment count, and add the byte to sum (mod 256).
  - If count==MAX_LEN, drop the byte. Pulse `ovf_err` only on the first drop of a frame, using a per-frame sticky flag.
  - `in_valid` && `in_last` moves the state to S_HEADER, even when that byte is dropped.
- **S_HEADER**: `tx_data`=HEADER.
- **S_LEN**: `tx_data`=count.
- **S_PAYLOAD**: `tx_data`=buffer[rd_ptr]. rd_ptr starts at 0 and increments on each handoff. Leave the state after the handoff of byte count-1.
- **S_CSUM**: `tx_data` = (count + sum) mod 256.
- **Handoff rule**
  - `tx_data_valid` = (state≠S_COLLECT) && `tx_data_ready` && !`rst`. This is combinational from registered terms only.
  - Every cycle with `tx_data_valid`=1 is one byte handed off. The transmitter latches the byte at that edge and drops `tx_data_ready` on the next cycle.
  - `tx_data_valid` is never asserted while `tx_data_ready`=0. The transmitter latches any byte presented while it is idle, so this rule prevents duplicated or lost bytes.
  - The handoff advances the state: HEADER→LEN→PAYLOAD→CSUM→COLLECT.
- **End of frame**: the CSUM handoff sets `frame_done`=1 for the next cycle. It also clears count, rd_ptr, sum and the overflow flag.
- Count is `$clog2(MAX_LEN+1)` bits wide. sum and checksum are 8 bits and wrap modulo 256.
- Minimum payload length is 1, since `in_last` always accompanies a byte. With MAX_LEN=255 the length byte is 8'hFF.

## Timing
- **Reset values**:
  - `in_ready`=1 (state S_COLLECT).
  - `tx_data_valid`=0, `tx_data`=HEADER.
  - `busy`=0, `frame_done`=0, `ovf_err`=0.
- The first payload byte is accepted on the first `in_valid` edge after reset release.
- From the `in_last` edge to the first possible `tx_data_valid` is one cycle, provided `tx_data_ready`=1.
- Each byte's handoff takes exactly one cycle. Inter-byte spacing is set by the transmitter.
- A frame of N payload bytes occupies exactly N+3 handoffs.
- `in_ready` returns to 1 in the cycle after the CSUM handoff, the same cycle as `frame_done`. A new payload may start in that cycle.
- `in_valid` during S_HEADER..S_CSUM is ignored (`in_ready`=0). Upstream holds the byte.
- Reset asserted mid-collect or mid-emit:
  - The next cycle is S_COLLECT with all counters cleared. The partial frame is discarded.
  - `tx_data_valid` is 0 during reset.
- After reset the transmitter holds `tx_data_ready`=0 for one cycle. The handoff rule covers this, so no byte is emitted.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (5 states);
  - the `FRAME_HEADER` default constant;
  - a `csum8` function (8-bit additive checksum).
- One sub-module `frame_buf`: a MAX_LEN×8 register file with a synchronous write port and a combinational read port at rd_ptr.
- The FSM, pointers, checksum and handshake logic live in the top module.

## Test plan
- Payload 01,02,03 (last on 03), `tx_data_ready` modelled by a UART transmitter bench model → bytes AA,03,01,02,03,09; one `frame_done` pulse; `ovf_err` never asserted.
- Single byte FF with `in_last` → AA,01,FF,00 (checksum wraps).
- MAX_LEN=4, payload 10,11,12,13,14,15 (last on 15) → AA,04,10,11,12,13,4A; `ovf_err` pulses exactly once, on byte 14.
- `tx_data_ready` held 0 for 100 cycles after `in_last` → `tx_data_valid` stays 0, `in_ready` stays 0, `busy`=1; bytes resume with no loss once ready rises.
- `rst` pulsed after the LEN byte → no further valid pulses; next payload AB (last) yields AA,01,AB,AC.
- `in_valid` held high with `in_last` across `frame_done` → the next frame starts collecting in the `frame_done` cycle with no byte dropped.
